ntt_pass_sequencer: RTL and testbench

Parametrised sequencer for one (i)NTT pass over the E-lane butterfly datapath. It supports both transform directions, a configurable lane count and pipeline latency, reduced ring sizes and read-side backpressure. The block issues buffer-RAM read addresses, twiddle-RAM base addresses and per-stage skip controls, then tracks beats through a fixed-latency valid pipeline to produce write addresses. It sits between the FHE ALU command decoder and the butterfly array, and replaces the single-direction, fixed-E controller.

---
 rtl/ntt_pass_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_ntt_pass_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ntt_pass_sequencer.sv
// ntt_pass_sequencer: address and control sequencer for one (i)NTT pass over
// the E-lane butterfly datapath. Issues read beats, twiddle base addresses and
// stage skip controls, and turns a fixed-latency valid pipeline into writes.
module ntt_pass_sequencer #(
  parameter int LOG_N    = 12,
  parameter int LOG_E    = 3,
  parameter int RD_LAT   = 2,
  parameter int PIPE_LAT = 12,
  localparam int AW  = LOG_N - LOG_E,
  localparam int TW  = AW + 1,
  localparam int LVW = $clog2(LOG_E + 1),
  localparam int LNW = $clog2(LOG_N)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic           abort,
  input  logic           mode,
  input  logic [LVW-1:0] levels,
  input  logic [LNW-1:0] base_level,
  input  logic [LNW-1:0] diff_logn,
  input  logic           stall,
  output logic           busy,
  output logic           done,
  output logic           cfg_err,
  output logic           rd_en,
  output logic [AW-1:0]  rd_addr,
  output logic [TW-1:0]  tw_addr,
  output logic           dp_valid,
  output logic [TW-1:0]  dp_tw_addr,
  output logic [LOG_E-1:0] skip_mask,
  output logic           wr_en,
  output logic [AW-1:0]  wr_addr
);

  localparam int DEPTH = RD_LAT + PIPE_LAT;
  localparam int GW    = $clog2(AW + 1);
  localparam logic [AW-1:0] AW_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TW_ONE = {{(TW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_r, state_next_s;
  logic              mode_r;
  logic [LNW-1:0]    base_r;
  logic [GW-1:0]     gap_r;
  logic [AW-1:0]     last_idx_r;
  logic [AW-1:0]     load_idx_r, store_idx_r;
  logic [DEPTH-1:0]  vpipe_r;
  logic [TW-1:0]     tw_pipe_r [RD_LAT];
  logic [LOG_E-1:0]  skip_r;
  logic              done_r, cfg_err_r, busy_r;

  logic [31:0]       lev_ext_s, base_ext_s, diff_ext_s, log2m_s;
  logic              cfg_bad_s, accept_s, last_wr_s;
  logic [AW-1:0]     last_s, chunk_s;
  logic [GW-1:0]     gap_s;
  logic [LOG_E-1:0]  skip_s;
  logic [TW-1:0]     tw_one_s, tw_addr_s;
  logic              rd_en_s;

  // Validate the requested configuration and derive beat count / gap bits.
  always_comb begin
    lev_ext_s  = {{(32-LVW){1'b0}}, levels};
    base_ext_s = {{(32-LNW){1'b0}}, base_level};
    diff_ext_s = {{(32-LNW){1'b0}}, diff_logn};
    log2m_s    = AW - diff_ext_s;
    cfg_bad_s  = (lev_ext_s == 32'd0) || (lev_ext_s > LOG_E) ||
                 (diff_ext_s > AW) || (base_ext_s > log2m_s);
    last_s     = AW'((32'd1 << log2m_s) - 32'd1);
    gap_s      = GW'(log2m_s - base_ext_s);
    for (int i = 0; i < LOG_E; i++) begin
      if (mode) begin
        skip_s[i] = (i < (LOG_E - lev_ext_s));
      end else begin
        skip_s[i] = (i >= lev_ext_s);
      end
    end
    accept_s  = (state_r == ST_IDLE) && start && !abort && !cfg_bad_s;
    last_wr_s = vpipe_r[DEPTH-1] && (store_idx_r == last_idx_r);
  end

  // Read request and twiddle base address, aligned with the issued beat.
  always_comb begin
    rd_en_s  = (state_r == ST_LOAD) && !stall;
    chunk_s  = load_idx_r >> gap_r;
    tw_one_s = TW_ONE << base_r;
    if (!rd_en_s) begin
      tw_addr_s = {TW{1'b0}};
    end else if (mode_r) begin
      tw_addr_s = (tw_one_s << 1) - TW_ONE - {1'b0, chunk_s};
    end else begin
      tw_addr_s = tw_one_s + {1'b0, chunk_s};
    end
  end

  // Next-state decode; abort overrides every transition.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = ST_LOAD;
        else          state_next_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (rd_en_s && (load_idx_r == last_idx_r)) state_next_s = ST_DRAIN;
        else                                       state_next_s = ST_LOAD;
      end
      ST_DRAIN: begin
        if (last_wr_s) state_next_s = ST_IDLE;
        else           state_next_s = ST_DRAIN;
      end
      default: state_next_s = ST_IDLE;
    endcase
    if (abort) begin
      state_next_s = ST_IDLE;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // Configuration latch, beat indexes, valid/twiddle pipelines and pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_r      <= 1'b0;
      base_r      <= {LNW{1'b0}};
      gap_r       <= {GW{1'b0}};
      last_idx_r  <= {AW{1'b0}};
      load_idx_r  <= {AW{1'b0}};
      store_idx_r <= {AW{1'b0}};
      vpipe_r     <= {DEPTH{1'b0}};
      for (int i = 0; i < RD_LAT; i++) tw_pipe_r[i] <= {TW{1'b0}};
      skip_r      <= {LOG_E{1'b0}};
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else if (abort) begin
      load_idx_r  <= {AW{1'b0}};
      store_idx_r <= {AW{1'b0}};
      vpipe_r     <= {DEPTH{1'b0}};
      for (int i = 0; i < RD_LAT; i++) tw_pipe_r[i] <= {TW{1'b0}};
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      busy_r    <= (state_next_s != ST_IDLE);
      cfg_err_r <= (state_r == ST_IDLE) && start && cfg_bad_s;
      done_r    <= (state_r == ST_DRAIN) && last_wr_s;
      vpipe_r   <= {vpipe_r[DEPTH-2:0], rd_en_s};
      tw_pipe_r[0] <= tw_addr_s;
      for (int i = 1; i < RD_LAT; i++) tw_pipe_r[i] <= tw_pipe_r[i-1];
      if (accept_s) begin
        mode_r      <= mode;
        base_r      <= base_level;
        gap_r       <= gap_s;
        last_idx_r  <= last_s;
        skip_r      <= skip_s;
        load_idx_r  <= {AW{1'b0}};
        store_idx_r <= {AW{1'b0}};
      end else begin
        // Indexes saturate at M-1 so they never wrap inside a pass.
        if (rd_en_s && (load_idx_r != last_idx_r)) load_idx_r <= load_idx_r + AW_ONE;
        else                                        load_idx_r <= load_idx_r;
        if (vpipe_r[DEPTH-1] && (store_idx_r != last_idx_r)) store_idx_r <= store_idx_r + AW_ONE;
        else                                                  store_idx_r <= store_idx_r;
      end
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign cfg_err    = cfg_err_r;
  assign rd_en      = rd_en_s;
  assign rd_addr    = load_idx_r;
  assign tw_addr    = tw_addr_s;
  assign dp_valid   = vpipe_r[RD_LAT-1];
  assign dp_tw_addr = tw_pipe_r[RD_LAT-1];
  assign skip_mask  = skip_r;
  assign wr_en      = vpipe_r[DEPTH-1];
  assign wr_addr    = store_idx_r;

endmodule

// File: tb/tb_ntt_pass_sequencer.sv
// Self-checking bench for ntt_pass_sequencer: directed and randomized passes
// compared against a cycle-indexed behavioural model of the pass.
module tb_ntt_pass_sequencer;
  localparam int LOG_N = 12, LOG_E = 3, RD_LAT = 2, PIPE_LAT = 12;
  localparam int AW = LOG_N - LOG_E, TW = AW + 1;
  localparam int LVW = $clog2(LOG_E + 1), LNW = $clog2(LOG_N);
  localparam int DEPTH = RD_LAT + PIPE_LAT;
  localparam int MAXC = 200;

  logic clk = 1'b0, rstn = 1'b0;
  logic start = 1'b0, abort = 1'b0, mode = 1'b0, stall = 1'b0;
  logic [LVW-1:0] levels = '0;
  logic [LNW-1:0] base_level = '0, diff_logn = '0;
  logic busy, done, cfg_err, rd_en, dp_valid, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [TW-1:0] tw_addr, dp_tw_addr;
  logic [LOG_E-1:0] skip_mask;

  int total = 0, bad = 0;

  ntt_pass_sequencer #(.LOG_N(LOG_N), .LOG_E(LOG_E), .RD_LAT(RD_LAT), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .mode(mode),
    .levels(levels), .base_level(base_level), .diff_logn(diff_logn), .stall(stall),
    .busy(busy), .done(done), .cfg_err(cfg_err), .rd_en(rd_en), .rd_addr(rd_addr),
    .tw_addr(tw_addr), .dp_valid(dp_valid), .dp_tw_addr(dp_tw_addr),
    .skip_mask(skip_mask), .wr_en(wr_en), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_tw_addr"}, 32'(tw_addr), 32'd0);
    chk({tag, "_dp_valid"}, 32'(dp_valid), 32'd0);
    chk({tag, "_dp_tw_addr"}, 32'(dp_tw_addr), 32'd0);
    chk({tag, "_skip_mask"}, 32'(skip_mask), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
  endtask

  // One pass. Stall is high in [s_lo,s_hi] plus randomly with stall_pct%.
  // abort_c > 0 raises abort during that cycle. Start is sampled at edge 0.
  task automatic run_pass(input int md, input int lv, input int bl, input int dl,
                          input int stall_pct, input int s_lo, input int s_hi, input int abort_c);
    bit st[MAXC+1], rd[MAXC+1], wr[MAXC+1], dv[MAXC+1];
    int ra[MAXC+1], tw[MAXC+1], wa[MAXC+1];
    int m, g, issued, written, last_w, done_c, end_c, busy_end, sm;
    m = 1 << (AW - dl);
    g = AW - dl - bl;
    sm = 0;
    for (int i = 0; i < LOG_E; i++) begin
      if (md != 0) sm |= ((i < LOG_E - lv) ? 1 : 0) << i;
      else         sm |= ((i >= lv) ? 1 : 0) << i;
    end
    issued = 0; written = 0; last_w = 0;
    for (int c = 0; c <= MAXC; c++) begin
      st[c] = (c >= s_lo && c <= s_hi) || ($urandom_range(99) < stall_pct);
      rd[c] = (c >= 1) && (issued < m) && !st[c] && (abort_c == 0 || c <= abort_c);
      ra[c] = issued;
      tw[c] = 0;
      if (rd[c]) begin
        if (md != 0) tw[c] = ((2 << bl) - 1 - (issued >> g)) & ((1 << TW) - 1);
        else         tw[c] = ((1 << bl) + (issued >> g)) & ((1 << TW) - 1);
        issued++;
      end
      dv[c] = (c > RD_LAT) && rd[c-RD_LAT] && (abort_c == 0 || c <= abort_c);
      wr[c] = (c > DEPTH) && rd[c-DEPTH] && (abort_c == 0 || c <= abort_c);
      wa[c] = written;
      if (wr[c]) begin written++; last_w = c; end
    end
    done_c   = (abort_c != 0) ? -1 : last_w + 1;
    busy_end = (abort_c != 0) ? abort_c + 1 : done_c;
    end_c    = (abort_c != 0) ? abort_c + DEPTH + 2 : done_c;
    if (end_c > MAXC || (abort_c == 0 && written != m)) begin
      chk("model_budget", 32'(end_c), 32'(MAXC));
    end else begin
      @(negedge clk);
      mode = md[0]; levels = LVW'(lv); base_level = LNW'(bl); diff_logn = LNW'(dl);
      start = 1'b1; stall = 1'b0; abort = 1'b0;
      @(posedge clk);
      for (int c = 1; c <= end_c; c++) begin
        #1;
        start = 1'b0; stall = st[c]; abort = (c == abort_c);
        @(negedge clk);
        chk("rd_en", 32'(rd_en), 32'(rd[c]));
        if (rd[c]) chk("rd_addr", 32'(rd_addr), 32'(ra[c]));
        chk("tw_addr", 32'(tw_addr), 32'(tw[c]));
        chk("dp_valid", 32'(dp_valid), 32'(dv[c]));
        if (dv[c]) chk("dp_tw_addr", 32'(dp_tw_addr), 32'(tw[c-RD_LAT]));
        chk("wr_en", 32'(wr_en), 32'(wr[c]));
        if (wr[c]) chk("wr_addr", 32'(wr_addr), 32'(wa[c]));
        chk("done", 32'(done), 32'(c == done_c));
        chk("busy", 32'(busy), 32'(c < busy_end));
        chk("cfg_err", 32'(cfg_err), 32'd0);
        if (c < busy_end) chk("skip_mask", 32'(skip_mask), 32'(sm));
        if (c < end_c) @(posedge clk);
      end
      stall = 1'b0; abort = 1'b0;
    end
  endtask

  task automatic bad_start(input int lv, input int bl, input int dl);
    @(negedge clk);
    levels = LVW'(lv); base_level = LNW'(bl); diff_logn = LNW'(dl); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
    chk("cfg_err_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("cfg_err_clear", 32'(cfg_err), 32'd0);
    chk("cfg_err_busy2", 32'(busy), 32'd0);
    chk("cfg_err_no_rd", 32'(rd_en), 32'd0);
  endtask

  initial begin
    // Reset state.
    #2 chk_all_zero("reset");
    #20 rstn = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    // Baseline pass: M=8, forward, no stall.
    run_pass(0, 3, 0, 6, 0, -1, -1, 0);
    // Twiddle addressing with g=2 in both directions, levels=1.
    run_pass(0, 1, 1, 6, 0, -1, -1, 0);
    run_pass(1, 1, 1, 6, 0, -1, -1, 0);
    // Directed stall cycles 3..5.
    run_pass(0, 3, 0, 6, 0, 3, 5, 0);
    // Abort in cycle 10, then an immediate full pass.
    run_pass(0, 3, 0, 6, 0, -1, -1, 10);
    run_pass(1, 2, 2, 6, 0, -1, -1, 0);
    // Abort mid-LOAD with random stall.
    run_pass(1, 2, 1, 5, 30, -1, -1, 5);

    // Rejected configurations.
    bad_start(0, 0, 6);
    bad_start(0, 2, 0);
    bad_start(3, 4, 6);
    bad_start(3, 10, 0);

    // Randomized legal passes.
    for (int k = 0; k < 8; k++) begin
      int dl, lv, bl, md;
      dl = $urandom_range(7, 5);
      lv = $urandom_range(LOG_E, 1);
      bl = $urandom_range(AW - dl, 0);
      md = $urandom_range(1, 0);
      run_pass(md, lv, bl, dl, 30, -1, -1, 0);
    end

    // Asynchronous reset during the write phase.
    @(negedge clk);
    mode = 1'b0; levels = 2'd3; base_level = 4'd0; diff_logn = 4'd6; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (16) @(posedge clk);
    #2 rstn = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("post_rst_wr_en", 32'(wr_en), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    run_pass(1, 3, 0, 7, 20, -1, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
